j_cmp_match: RTL and testbench
==============================

# j_cmp_match

Parametrised multi-entry registered match unit for Jerry, generalising the fixed 6-bit equality compare into an ENTRIES-deep table of WIDTH-bit tags. Queries are compared against all valid entries in parallel. A registered hit vector, a lowest-index hit encoding and a saturating hit counter are returned one cycle later. It serves address/opcode watch and decode-match duty alongside the DSP control logic.

## Interface
Parameters:
- WIDTH, 6: tag and query width in bits (≥1).
- ENTRIES, 4: number of table entries (2..16).
- IDXW, $clog2(ENTRIES): entry index width (derived; do not override).
- CNTW, 8: hit counter width.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ld  in  1  load strobe: write entry ld_idx this cycle.
- ld_idx  in  IDXW  entry to load; values ≥ ENTRIES ignored (no write).
- ld_tag  in  WIDTH  tag value to store.
- ld_mask  in  WIDTH  don't-care mask, 1 = bit ignored (only with CMP_MASK_EN).
- ld_valid  in  1  valid bit written with the entry (0 invalidates).
- clr_all  in  1  invalidate all entries and zero hit_cnt.
- cmp_req  in  1  compare query this cycle.
- cmp_data  in  WIDTH  query value.
- match_vld  out  1  results below valid (pulse, one per cmp_req).
- hit  out  1  any valid entry matched.
- hit_vec  out  ENTRIES  per-entry match, bit i = entry i.
- hit_idx  out  IDXW  lowest matching index; 0 when hit=0.
- hit_cnt  out  CNTW  saturating count of queries with hit=1.

## Operation
- Entry i matches when valid[i] and every bit of cmp_data equals tag[i] (with CMP_MASK_EN: bits with mask[i]=1 excluded).
- Per-bit equality is XNOR; entry match is the AND-reduction, as in the existing 6-bit compare.
- hit = OR of the match vector. hit_idx is the priority encode of the lowest set bit.
- hit_cnt increments by 1 on each registered result with hit=1. It holds at 2^CNTW−1, never wraps.
- Load: on ld with a legal ld_idx, tag/mask/valid[ld_idx] are written at the clock edge.
- Simultaneous ld and cmp_req in the same cycle: the compare uses the pre-load contents. The new entry is visible from the next cycle.
- clr_all has priority over ld in the same cycle: all valid bits are cleared and the ld is dropped.
- clr_all with cmp_req: the compare uses the pre-clear contents. hit_cnt ends at 0 regardless of that result.
- Tags and masks are not cleared by reset or clr_all; only valid bits are cleared. Entries with valid=0 never match.

## Timing
- Latency 1: cmp_req at edge n produces match_vld=1 and results during cycle n+1.
- Throughput: one query per cycle, back-to-back, with no stall or backpressure.
- Result outputs hold their last value while match_vld=0.
- hit_cnt updates at the same edge that registers the hit.
- Reset values: match_vld=0, hit=0, hit_vec=0, hit_idx=0, hit_cnt=0, all valid=0.
- Reset asserted mid-stream: a pending result is discarded, with no match_vld after release.
- First compare after release: issued at the first edge with reset low.

## Configuration
- CMP_MASK_EN defined: per-entry mask storage and ld_mask port present; masked bits are don't-care.
- CMP_MASK_EN undefined: no mask storage, ld_mask port absent, exact compare on all WIDTH bits.

## Structure
- Shared package j_cmp_pkg holds:
  - the priority-encode function (lowest set bit to index);
  - the saturation constant helper;
  - the default WIDTH/ENTRIES localparams.
- One sub-module, j_cmp_n: parametrised combinational WIDTH-bit equality (with optional mask input), instantiated ENTRIES times.
- Table storage, valid bits, result registers and counter live in the top.

## Test plan
- Reset, then load entry 2 with tag 6'h2A valid; query 6'h2A -> next cycle match_vld=1, hit=1, hit_vec=4'b0100, hit_idx=2, hit_cnt=1.
- Load entries 1 and 3 both with 6'h15; query 6'h15 -> hit_vec=4'b1010, hit_idx=1. Query 6'h16 -> hit=0, hit_idx=0, hit_cnt unchanged.
- Same cycle ld entry 0 = 6'h07 and query 6'h07 -> hit=0. Repeat query next cycle -> hit=1, hit_idx=0.
- Run 300 consecutive hitting queries with CNTW=8 -> hit_cnt stops at 255. Assert clr_all -> hit_cnt=0 and all subsequent queries miss.
- With CMP_MASK_EN: entry 0 tag 6'h30 mask 6'h0F; queries 6'h3C and 6'h30 hit, 6'h20 misses.
- Assert reset on the edge after cmp_req -> no match_vld pulse; all outputs 0 while reset is high.

Source files
------------

// File: rtl/j_cmp_pkg.sv
// Shared definitions for the j_cmp match unit: default sizes, the lowest-set-bit
// priority encoder and the counter saturation helper.
package j_cmp_pkg;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_ENTRIES = 4;
    localparam int DEF_CNTW    = 8;

    // Index of the lowest set bit of a match vector of up to 16 entries; 0 when empty.
    function automatic logic [3:0] prio_enc(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[3:0];
            end
        end
        return idx;
    endfunction

    // All-ones value of a bits-wide counter (bits <= 32).
    function automatic logic [31:0] sat_max(input int unsigned bits);
        if (bits >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/j_cmp_n.sv
// WIDTH-bit combinational tag equality: bitwise XNOR, AND-reduced.
// Build option CMP_MASK_EN adds a mask input whose set bits are don't-care.
module j_cmp_n #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             eq
);

`ifdef CMP_MASK_EN
    assign eq = &((a ~^ b) | mask);
`else
    assign eq = &(a ~^ b);
`endif

endmodule

// File: rtl/j_cmp_match.sv
// ENTRIES-deep registered tag match table with hit vector, lowest-index encode and
// saturating hit counter. Build option CMP_MASK_EN adds per-entry don't-care masks.
module j_cmp_match
    import j_cmp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int IDXW    = $clog2(ENTRIES),
    parameter int CNTW    = DEF_CNTW
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [IDXW-1:0]    ld_idx,
    input  logic [WIDTH-1:0]   ld_tag,
`ifdef CMP_MASK_EN
    input  logic [WIDTH-1:0]   ld_mask,
`endif
    input  logic               ld_valid,
    input  logic               clr_all,
    input  logic               cmp_req,
    input  logic [WIDTH-1:0]   cmp_data,
    output logic               match_vld,
    output logic               hit,
    output logic [ENTRIES-1:0] hit_vec,
    output logic [IDXW-1:0]    hit_idx,
    output logic [CNTW-1:0]    hit_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(sat_max(CNTW));

    logic [WIDTH-1:0]   tag_q [ENTRIES];
`ifdef CMP_MASK_EN
    logic [WIDTH-1:0]   mask_q [ENTRIES];
`endif
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] eq_vec;
    logic [ENTRIES-1:0] match_vec;
    logic               any_hit;
    logic [IDXW-1:0]    first_idx;
    logic               ld_wr;

    // clr_all wins over ld; out-of-range indices are silently dropped.
    assign ld_wr = ld && !clr_all && ({1'b0, ld_idx} < (IDXW + 1)'(ENTRIES));

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
        j_cmp_n #(.WIDTH(WIDTH)) u_cmp (
            .a    (cmp_data),
            .b    (tag_q[g]),
`ifdef CMP_MASK_EN
            .mask (mask_q[g]),
`endif
            .eq   (eq_vec[g])
        );
    end

    assign match_vec = eq_vec & valid_q;
    assign any_hit   = |match_vec;
    assign first_idx = IDXW'(prio_enc(16'(match_vec)));

    // Tag and mask storage is deliberately left out of reset; valid bits gate it.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (ld_wr && ld_idx == IDXW'(i)) begin
                tag_q[i] <= ld_tag;
`ifdef CMP_MASK_EN
                mask_q[i] <= ld_mask;
`endif
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (ld_wr) begin
            valid_q[ld_idx] <= ld_valid;
        end
    end

    // match_vld pulses once per cmp_req, one cycle later; there is no ready, so every
    // request is accepted and result registers hold their value between pulses.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            match_vld <= 1'b0;
            hit       <= 1'b0;
            hit_vec   <= '0;
            hit_idx   <= '0;
        end else begin
            match_vld <= cmp_req;
            if (cmp_req) begin
                hit     <= any_hit;
                hit_vec <= match_vec;
                hit_idx <= first_idx;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            hit_cnt <= '0;
        end else if (clr_all) begin
            hit_cnt <= '0;
        end else if (cmp_req && any_hit && hit_cnt != CNT_MAX) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_j_cmp_match.sv
// Self-checking bench for j_cmp_match: directed cases plus random traffic against
// a table-level reference model. Honours CMP_MASK_EN when defined.
module tb_j_cmp_match;

    localparam int WIDTH   = 6;
    localparam int ENTRIES = 4;
    localparam int IDXW    = 2;
    localparam int CNTW    = 8;
    localparam int CNT_MAX = (1 << CNTW) - 1;
    localparam int EW      = ENTRIES + IDXW + 1;

    // clock / reset
    logic               sys_clk = 1'b0;
    logic               reset;
    logic               ld;
    logic [IDXW-1:0]    ld_idx;
    logic [WIDTH-1:0]   ld_tag;
`ifdef CMP_MASK_EN
    logic [WIDTH-1:0]   ld_mask;
`endif
    logic               ld_valid;
    logic               clr_all;
    logic               cmp_req;
    logic [WIDTH-1:0]   cmp_data;
    logic               match_vld;
    logic               hit;
    logic [ENTRIES-1:0] hit_vec;
    logic [IDXW-1:0]    hit_idx;
    logic [CNTW-1:0]    hit_cnt;

    always #5 sys_clk = ~sys_clk;

    j_cmp_match #(
        .WIDTH  (WIDTH),
        .ENTRIES(ENTRIES),
        .CNTW   (CNTW)
    ) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .ld       (ld),
        .ld_idx   (ld_idx),
        .ld_tag   (ld_tag),
`ifdef CMP_MASK_EN
        .ld_mask  (ld_mask),
`endif
        .ld_valid (ld_valid),
        .clr_all  (clr_all),
        .cmp_req  (cmp_req),
        .cmp_data (cmp_data),
        .match_vld(match_vld),
        .hit      (hit),
        .hit_vec  (hit_vec),
        .hit_idx  (hit_idx),
        .hit_cnt  (hit_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    // reference model: the table as plain arrays, results as {vec, idx, hit}
    logic [WIDTH-1:0] m_tag   [ENTRIES];
    logic [WIDTH-1:0] m_mask  [ENTRIES];
    logic             m_valid [ENTRIES];
    int               m_cnt;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    last_res;

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
        end
        m_cnt    = 0;
        last_res = '0;
        exp_q.delete();
    endtask

    // One clock of stimulus: drive at negedge, predict, check just after posedge.
    task automatic cycle(input logic i_ld, input int idx, input logic [WIDTH-1:0] tag,
                         input logic [WIDTH-1:0] mask, input logic lv, input logic clr,
                         input logic req, input logic [WIDTH-1:0] data);
        logic [ENTRIES-1:0] vec;
        int                 first;
        logic [WIDTH-1:0]   mk;
        @(negedge sys_clk);
        ld       = i_ld;
        ld_idx   = IDXW'(idx);
        ld_tag   = tag;
`ifdef CMP_MASK_EN
        ld_mask  = mask;
`endif
        ld_valid = lv;
        clr_all  = clr;
        cmp_req  = req;
        cmp_data = data;
        if (req) begin
            vec   = '0;
            first = -1;
            for (int i = 0; i < ENTRIES; i++) begin
`ifdef CMP_MASK_EN
                mk = m_mask[i];
`else
                mk = '0;
`endif
                if (m_valid[i] && ((data | mk) == (m_tag[i] | mk))) begin
                    vec[i] = 1'b1;
                    if (first < 0) first = i;
                end
            end
            if (first < 0) first = 0;
            exp_q.push_back({vec, IDXW'(first), |vec});
            if (|vec && m_cnt < CNT_MAX) m_cnt++;
        end
        if (clr) begin
            m_cnt = 0;
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (i_ld && idx < ENTRIES) begin
            m_tag[idx]   = tag;
            m_mask[idx]  = mask;
            m_valid[idx] = lv;
        end
        @(posedge sys_clk);
        #1;
        check("match_vld", match_vld, req);
        if (req && exp_q.size() > 0) last_res = exp_q.pop_front();
        check("hit", hit, last_res[0]);
        check("hit_idx", hit_idx, last_res[IDXW:1]);
        check("hit_vec", hit_vec, last_res[EW-1:IDXW+1]);
        check("hit_cnt", hit_cnt, m_cnt);
    endtask

    task automatic query(input logic [WIDTH-1:0] data);
        cycle(1'b0, 0, '0, '0, 1'b0, 1'b0, 1'b1, data);
    endtask

    task automatic load(input int idx, input logic [WIDTH-1:0] tag, input logic [WIDTH-1:0] mask);
        cycle(1'b1, idx, tag, mask, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ld       = 1'b0;
        ld_idx   = '0;
        ld_tag   = '0;
`ifdef CMP_MASK_EN
        ld_mask  = '0;
`endif
        ld_valid = 1'b0;
        clr_all  = 1'b0;
        cmp_req  = 1'b0;
        cmp_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_tag[i]  = '0;
            m_mask[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_match_vld", match_vld, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_vec", hit_vec, 0);
        check("rst_hit_idx", hit_idx, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        @(negedge sys_clk);
        reset = 1'b0;

        // single entry hit
        load(2, 6'h2A, '0);
        query(6'h2A);
        check("tp1_vec", hit_vec, 4'b0100);
        check("tp1_idx", hit_idx, 2);
        check("tp1_cnt", hit_cnt, 1);

        // two entries, lowest index wins; then a miss
        load(1, 6'h15, '0);
        load(3, 6'h15, '0);
        query(6'h15);
        check("tp2_vec", hit_vec, 4'b1010);
        check("tp2_idx", hit_idx, 1);
        query(6'h16);
        check("tp2_miss_hit", hit, 0);
        check("tp2_miss_idx", hit_idx, 0);
        check("tp2_miss_cnt", hit_cnt, 2);

        // load and compare in one cycle sees the old contents
        cycle(1'b1, 0, 6'h07, '0, 1'b1, 1'b0, 1'b1, 6'h07);
        check("tp3_same_cycle", hit, 0);
        query(6'h07);
        check("tp3_next_hit", hit, 1);
        check("tp3_next_idx", hit_idx, 0);

        // counter saturation
        for (int i = 0; i < 300; i++) query(6'h2A);
        check("tp4_sat", hit_cnt, 255);

        // clear with compare: result from old table, counter ends at zero
        cycle(1'b0, 0, '0, '0, 1'b0, 1'b1, 1'b1, 6'h15);
        check("tp4_clr_hit", hit, 1);
        check("tp4_clr_cnt", hit_cnt, 0);
        query(6'h15);
        check("tp4_after_clr", hit, 0);
        query(6'h2A);

        // clear drops a simultaneous load
        cycle(1'b1, 1, 6'h11, '0, 1'b1, 1'b1, 1'b0, '0);
        query(6'h11);
        check("clr_drops_ld", hit, 0);

        // mask behaviour (exact compare when masks are not built in)
        load(0, 6'h30, 6'h0F);
        query(6'h3C);
`ifdef CMP_MASK_EN
        check("mask_3c", hit, 1);
`else
        check("exact_3c", hit, 0);
`endif
        query(6'h30);
        check("mask_30", hit, 1);
        query(6'h20);
        check("mask_20", hit, 0);

        // invalidating load
        cycle(1'b1, 0, 6'h30, '0, 1'b0, 1'b0, 1'b0, '0);
        query(6'h30);
        check("invalidated", hit, 0);

        // random traffic, small tag space so hits are common
        for (int n = 0; n < 500; n++) begin
            cycle(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, ENTRIES - 1)),
                  WIDTH'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 7)));
        end

        // reset arrives before a pending request is registered
        load(2, 6'h2A, '0);
        @(negedge sys_clk);
        ld       = 1'b0;
        clr_all  = 1'b0;
        cmp_req  = 1'b1;
        cmp_data = 6'h2A;
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge sys_clk);
        #1;
        check("midrst_vld", match_vld, 0);
        check("midrst_hit", hit, 0);
        check("midrst_vec", hit_vec, 0);
        check("midrst_idx", hit_idx, 0);
        check("midrst_cnt", hit_cnt, 0);
        @(negedge sys_clk);
        cmp_req = 1'b0;
        @(negedge sys_clk);
        reset = 1'b0;
        cycle(1'b0, 0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        check("post_rst_no_pulse", match_vld, 0);
        query(6'h2A);
        check("post_rst_valid_clear", hit, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
